// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL lock sequencer: state encoding,
// default frequency/gain words and saturating/absolute-difference helpers.
package pll_pkg;

  localparam int unsigned FW = 32;

  localparam logic [FW-1:0] F0_DEF          = 32'hA410;
  localparam logic [FW-1:0] DELF_COARSE_DEF = 32'h1388;
  localparam logic [FW-1:0] DELF_FINE_DEF   = 32'h01F4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_COARSE = 3'd2,
    ST_FINE   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5,
    ST_HOLD   = 3'd6
  } state_t;

  function automatic logic [FW-1:0] abs_diff(input logic [FW-1:0] a,
                                              input logic [FW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
    return (v == '1) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/link_edge_det.sv
// Two-flop synchroniser for the asynchronous link input followed by a
// registered rising-edge detector (one-cycle pulse, three-cycle latency).
module link_edge_det (
  input  logic clk,
  input  logic nrst,
  input  logic i_link,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_edge;

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= i_link;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= r_sync2 & ~r_sync3;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL acquisition sequencer: arm delay, coarse then fine lock phases with
// per-phase timeout and retry, lock monitoring. Define PLL_SEQ_HOLDOVER_EN
// to hold frequency-ready for a holdover window after power-link loss.
module pll_lock_sequencer
  import pll_pkg::*;
#(
  parameter logic [FW-1:0] F0          = F0_DEF,
  parameter logic [FW-1:0] DELF_COARSE = DELF_COARSE_DEF,
  parameter logic [FW-1:0] DELF_FINE   = DELF_FINE_DEF,
  parameter logic [FW-1:0] TOL         = 32'h0100,
  parameter int unsigned   LOCK_N      = 8,
  parameter int unsigned   ARM_CYC     = 16,
  parameter int unsigned   TIMEOUT     = 2_000_000,
  parameter int unsigned   MAX_RETRY   = 3
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic          swipt_alive,
  input  logic          link,
  input  logic [FW-1:0] f_meas,
  output logic          pll_en,
  output logic          freq_rdy,
  output logic [FW-1:0] f0_cfg,
  output logic [FW-1:0] delf_cfg,
  output logic          locked,
  output logic          fail,
  output logic [1:0]    retry_cnt,
  output logic [2:0]    state_o
);

`ifdef PLL_SEQ_HOLDOVER_EN
  localparam int unsigned HOLD_CYC = 1024;
`endif

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_retry;
  logic [1:0]    w_retry_next;
  logic [FW-1:0] r_timer;
  logic [FW-1:0] r_stable;
  logic [FW-1:0] r_fref;
  logic          r_have_ref;

  logic          w_edge;
  logic [FW-1:0] w_diff;
  logic [FW-1:0] w_cnt_inc;
  logic          w_stable_edge;
  logic          w_jump_edge;
  logic          w_lock_ev;
  logic          w_phase_done;
  logic [1:0]    w_retry_sat;

  link_edge_det u_edge (
    .clk    (clk),
    .nrst   (nrst),
    .i_link (link),
    .o_edge (w_edge)
  );

  always_comb begin
    w_next        = r_state;
    w_retry_next  = r_retry;
    w_diff        = abs_diff(f_meas, r_fref);
    w_cnt_inc     = sat_inc(r_stable);
    w_stable_edge = w_edge & r_have_ref & (w_diff <= TOL);
    w_jump_edge   = w_edge & r_have_ref & (w_diff > TOL);
    w_lock_ev     = w_stable_edge & (w_cnt_inc >= LOCK_N);
    w_phase_done  = (r_timer >= TIMEOUT - 1);
    w_retry_sat   = (32'(r_retry) >= MAX_RETRY) ? r_retry : r_retry + 2'd1;

    // Link loss is checked first in every active state so it overrides
    // lock, timeout and edge events arriving in the same cycle.
    case (r_state)
      ST_IDLE: begin
        if (start && swipt_alive) w_next = ST_ARM;
      end
      ST_ARM: begin
        if (!swipt_alive)                 w_next = ST_IDLE;
        else if (r_timer >= ARM_CYC - 1)  w_next = ST_COARSE;
      end
      ST_COARSE, ST_FINE: begin
        if (!swipt_alive) begin
          w_next = ST_IDLE;
        end else if (w_lock_ev) begin
          w_next = (r_state == ST_COARSE) ? ST_FINE : ST_LOCKED;
        end else if (w_phase_done) begin
          w_retry_next = w_retry_sat;
          w_next       = (32'(r_retry) < MAX_RETRY - 1) ? ST_ARM : ST_FAIL;
        end
      end
      ST_LOCKED: begin
        if (!swipt_alive) begin
`ifdef PLL_SEQ_HOLDOVER_EN
          w_next = ST_HOLD;
`else
          w_next = ST_IDLE;
`endif
        end else if (w_jump_edge) begin
          w_retry_next = w_retry_sat;
          w_next       = ST_COARSE;
        end
      end
      ST_FAIL: begin
        if (start) begin
          w_retry_next = '0;
          w_next       = ST_ARM;
        end
      end
`ifdef PLL_SEQ_HOLDOVER_EN
      ST_HOLD: begin
        if (swipt_alive)                  w_next = ST_ARM;
        else if (r_timer >= HOLD_CYC - 1) w_next = ST_IDLE;
      end
`endif
      default: w_next = ST_IDLE;
    endcase

    if (w_next == ST_IDLE) w_retry_next = '0;
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state    <= ST_IDLE;
      r_retry    <= '0;
      r_timer    <= '0;
      r_stable   <= '0;
      r_fref     <= '0;
      r_have_ref <= 1'b0;
    end else begin
      r_state <= w_next;
      r_retry <= w_retry_next;
      if (w_next != r_state) begin
        // Phase entry restarts timing and stability tracking; entering
        // LOCKED keeps the last edge as reference for drift monitoring.
        r_timer    <= '0;
        r_stable   <= '0;
        r_have_ref <= (w_next == ST_LOCKED);
        if (w_next == ST_LOCKED) r_fref <= f_meas;
      end else begin
        if (r_state inside {ST_ARM, ST_COARSE, ST_FINE, ST_HOLD})
          r_timer <= sat_inc(r_timer);
        if (w_edge && (r_state inside {ST_COARSE, ST_FINE, ST_LOCKED})) begin
          r_fref     <= f_meas;
          r_have_ref <= 1'b1;
          if (r_state != ST_LOCKED)
            r_stable <= w_stable_edge ? w_cnt_inc : '0;
        end
      end
    end
  end

  always_comb begin
    pll_en   = 1'b0;
    freq_rdy = 1'b0;
    locked   = 1'b0;
    fail     = 1'b0;
    delf_cfg = DELF_COARSE;
    case (r_state)
      ST_ARM, ST_COARSE: pll_en = 1'b1;
      ST_FINE: begin
        pll_en   = 1'b1;
        delf_cfg = DELF_FINE;
      end
      ST_LOCKED: begin
        pll_en   = 1'b1;
        locked   = 1'b1;
        freq_rdy = 1'b1;
        delf_cfg = DELF_FINE;
      end
      ST_FAIL: fail = 1'b1;
      ST_HOLD: begin
        freq_rdy = 1'b1;
        delf_cfg = DELF_FINE;
      end
      default: ;
    endcase
  end

  assign f0_cfg    = F0;
  assign retry_cnt = r_retry;
  assign state_o   = r_state;

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- F0, 32'hA410, centre frequency word.
- DELF_COARSE, 32'h1388, coarse-gain word.
- DELF_FINE, 32'h01F4, fine-gain word.
- TOL, 32'h0100, max |delta f| between link edges counted as stable.
- LOCK_N, 8, consecutive stable edges required.
- ARM_CYC, 16, arm delay in clk cycles.
- TIMEOUT, 2_000_000, clk cycles allowed per acquisition phase.
- MAX_RETRY, 3, acquisition attempts before FAIL.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- nrst, in, 1, reset: synchronous, active-high.
- start, in, 1, one-cycle request to begin acquisition.
- swipt_alive, in, 1, power link present.
- link, in, 1, asynchronous reference edge source.
- f_meas, in, 32, loop frequency word.
- pll_en, out, 1, loop enable.
- freq_rdy, out, 1, free-run frequency valid.
- f0_cfg, out, 32, centre-frequency word to loop.
- delf_cfg, out, 32, gain word to loop.
- locked, out, 1, lock achieved.
- fail, out, 1, lock abandoned.
- retry_cnt, out, 2, attempts used.
- state_o, out, 3, current state encoding.

Function
REQ-003 link SHALL pass a 2-flop synchroniser; a link edge SHALL be a synchronised 0->1 transition (one-cycle pulse, 3-cycle latency).
REQ-004 States SHALL be IDLE=0, ARM=1, COARSE=2, FINE=3, LOCKED=4, FAIL=5, HOLD=6.
REQ-005 IDLE: all outputs 0 except f0_cfg=F0 and delf_cfg=DELF_COARSE; start with swipt_alive=1 -> ARM; start with swipt_alive=0 SHALL be ignored.
REQ-006 ARM: pll_en=1 and delf_cfg=DELF_COARSE; after exactly ARM_CYC cycles -> COARSE.
REQ-007 At each link edge in COARSE/FINE the block SHALL compare f_meas with f_meas latched at the previous link edge, using unsigned absolute difference. If the difference is <=TOL the stable counter SHALL increment; otherwise it SHALL clear. The first edge after phase entry only latches.
REQ-008 COARSE: stable counter reaching LOCK_N -> FINE, with delf_cfg=DELF_FINE from the next cycle; stable counter and phase timer SHALL clear.
REQ-009 FINE: stable counter reaching LOCK_N -> LOCKED.
REQ-010 LOCKED: locked=1 and freq_rdy=1; any link-edge difference >TOL -> COARSE with retry_cnt+1 and delf_cfg=DELF_COARSE.
REQ-011 Phase timer SHALL count cycles in COARSE/FINE.
- Reaching TIMEOUT with retry_cnt<MAX_RETRY-1 -> ARM, retry_cnt+1.
- Otherwise -> FAIL.
REQ-012 FAIL: fail=1 and pll_en=0; held until start, which SHALL clear retry_cnt and fail and enter ARM.
REQ-013 swipt_alive=0 in ARM, COARSE or FINE -> IDLE next cycle; this SHALL take priority over lock, timeout and edge events in the same cycle.
REQ-014 start asserted outside IDLE/FAIL SHALL be ignored.
REQ-015 retry_cnt SHALL saturate at MAX_RETRY and SHALL NOT wrap.
REQ-016 Counters SHALL be 32-bit; stable counter and timer SHALL saturate, not wrap.

Reset
REQ-017 nrst=1 at a clk edge SHALL force IDLE from any state, including mid-acquisition.
- Outputs: pll_en=0, freq_rdy=0, locked=0, fail=0, retry_cnt=0, f0_cfg=F0, delf_cfg=DELF_COARSE.
- Synchroniser, latched f_meas, stable counter and timer SHALL clear.
REQ-018 Reset SHALL take priority over all other inputs.

Configuration
REQ-019 With PLL_SEQ_HOLDOVER_EN defined, swipt_alive=0 in LOCKED SHALL enter HOLD.
- HOLD keeps freq_rdy=1, locked=0 and pll_en=0 for 1024 cycles, then -> IDLE.
- swipt_alive=1 during HOLD SHALL return to ARM.
REQ-020 Without PLL_SEQ_HOLDOVER_EN, swipt_alive=0 in LOCKED -> IDLE next cycle, HOLD is unreachable and state_o never equals 6.

Structure
REQ-021 A shared package pll_pkg SHALL hold the state enum, the F0/DELF default constants and the frequency-word width.
REQ-022 The synchroniser and edge detector SHALL be sub-module link_edge_det; the FSM, timer and comparator stay in the top module.

Verification
REQ-023 Reset: nrst=1 for 2 cycles mid-FINE -> next cycle state_o=0, pll_en=0, delf_cfg=32'h1388.
REQ-024 Clean lock, TOL=32'h100, LOCK_N=8:
- start, then f_meas constant 32'hA410 across link edges.
- Expect ARM for 16 cycles, then COARSE.
- After 9 edges, FINE with delf_cfg=32'h1F4.
- After 9 more edges, locked=1 and freq_rdy=1.
REQ-025 Jitter: a delta of 32'h101 at the 5th edge -> stable counter clears and lock needs 8 further stable edges.
REQ-026 Timeout: TIMEOUT=1000, f_meas alternating +/-32'h200 -> retry_cnt steps 1, 2, then fail=1 at the 3rd timeout; start -> ARM with retry_cnt=0.
REQ-027 Loss of power: swipt_alive drops in LOCKED.
- Macro defined: freq_rdy=1 for 1024 cycles, then IDLE.
- Macro undefined: IDLE next cycle.
REQ-028 Simultaneous events: swipt_alive=0 in the same cycle as the LOCK_N-th stable edge in FINE -> IDLE and locked stays 0.
